// File: rtl/perm_engine.sv
// Table-programmable bit-permutation engine with a 2-entry output FIFO.
// Define PERM_INV_EN to add the per-word inverse permutation network.
module perm_engine #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [7:0]       cfg_addr,
    input  logic [IDXW-1:0]  cfg_data,
    output logic             cfg_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_inv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // Buffer occupancy doubles as the FSM state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [IDXW-1:0]  tbl [WIDTH];
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [WIDTH-1:0] fwd_word;
    logic [WIDTH-1:0] perm_word;
    logic             push;
    logic             pop;

    // Entries that match no source bit (out of range) leave the output bit at 0.
    always_comb begin
        fwd_word = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (int'(tbl[i]) == k) fwd_word[i] = in_data[k];
            end
        end
    end

`ifdef PERM_INV_EN
    logic [WIDTH-1:0] inv_word;

    always_comb begin
        inv_word = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (int'(tbl[i]) == j) inv_word[j] = inv_word[j] | in_data[i];
            end
        end
    end

    assign perm_word = in_inv ? inv_word : fwd_word;
`else
    logic unused_inv;
    assign unused_inv = in_inv;
    assign perm_word  = fwd_word;
`endif

    // Handshake: a word moves on a cycle where valid and ready are both high at
    // the rising edge; ready never depends combinationally on the other side.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
            for (int i = 0; i < WIDTH; i++) tbl[i] <= IDXW'(i);
        end else begin
            cfg_err <= cfg_we && (int'(cfg_addr) >= WIDTH);
            for (int i = 0; i < WIDTH; i++) begin
                if (cfg_we && (int'(cfg_addr) == i)) tbl[i] <= cfg_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= perm_word;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case (state)
                EMPTY: if (push) state <= ONE;
                ONE: begin
                    if (push && !pop)      state <= FULL;
                    else if (pop && !push) state <= EMPTY;
                end
                FULL:    if (pop) state <= ONE;
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_perm_engine.sv
// Bench for perm_engine: directed literal cases plus randomized traffic checked
// every cycle against a queue-based model of the table and buffer.
module tb_perm_engine;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_we;
  logic [7:0]   cfg_addr;
  logic [4:0]   cfg_data;
  logic         cfg_err;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  int errors = 0;
  int checks = 0;

  perm_engine #(.WIDTH(W), .IDXW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model
  int           m_tbl [W];
  logic [W-1:0] exp_q [$];
  bit           err_exp = 0;
  bit           zero_exp = 0;
  bit           model_live = 0;

  function automatic logic [W-1:0] model_perm(input logic [W-1:0] d, input bit inv);
    logic [W-1:0] r = '0;
    for (int i = 0; i < W; i++) begin
      if (m_tbl[i] < W) begin
        if (inv) r[m_tbl[i]] = r[m_tbl[i]] | d[i];
        else     r[i] = d[m_tbl[i]];
      end
    end
    return r;
  endfunction

  // Inputs change only just after a rising edge, so values seen at the falling
  // edge are the ones the next rising edge will act on.
  initial begin
    forever begin
      @(negedge clk);
      if (model_live) begin
        chk("out_valid", out_valid, W'(exp_q.size() > 0));
        chk("in_ready", in_ready, W'(exp_q.size() < 2));
        chk("cfg_err", cfg_err, W'(err_exp));
        if (exp_q.size() > 0) chk("out_data", out_data, exp_q[0]);
        else if (zero_exp)    chk("out_data_rst", out_data, '0);
      end
      if (!rst_n) begin
        exp_q.delete();
        for (int i = 0; i < W; i++) m_tbl[i] = i;
        err_exp    = 0;
        zero_exp   = 1;
        model_live = 1;
      end else if (model_live) begin
        bit           do_push;
        bit           do_pop;
        bit           inv_eff;
        logic [W-1:0] w;
`ifdef PERM_INV_EN
        inv_eff = in_inv;
`else
        inv_eff = 0;
`endif
        do_push = in_valid && (exp_q.size() < 2);
        do_pop  = (exp_q.size() > 0) && out_ready;
        w = model_perm(in_data, inv_eff);
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) begin
          exp_q.push_back(w);
          zero_exp = 0;
        end
        err_exp = cfg_we && (cfg_addr >= 8'(W));
        if (cfg_we && cfg_addr < 8'(W)) m_tbl[cfg_addr] = int'(cfg_data);
      end
    end
  end

  // driver tasks (called at posedge+1)
  task automatic cfg_write(input logic [7:0] a, input logic [4:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic inv);
    bit done = 0;
    in_data = d; in_inv = inv; in_valid = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    in_valid = 1'b0;
    chk("send_accepted", W'(done), W'(1));
  endtask

  task automatic expect_out(input logic [W-1:0] exp, input string name);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk({name, "_valid"}, W'(out_valid), W'(1));
    chk(name, out_data, exp);
    @(posedge clk); #1;
  endtask

  int des_p [W] = '{15, 6, 19, 20, 28, 11, 27, 16, 0, 14, 22, 25, 4, 17, 30, 9,
                    1, 7, 23, 13, 31, 26, 2, 8, 18, 12, 29, 5, 21, 10, 3, 24};

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b1;

    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;

    send_word(32'hDEAD_BEEF, 1'b0);
    expect_out(32'hDEAD_BEEF, "identity");

    cfg_write(8'd40, 5'd3);
    @(negedge clk);
    chk("cfg_err_pulse", W'(cfg_err), W'(1));
    @(negedge clk);
    chk("cfg_err_clear", W'(cfg_err), W'(0));
    @(posedge clk); #1;
    send_word(32'h1234_5678, 1'b0);
    expect_out(32'h1234_5678, "identity_after_err");

    out_ready = 1'b0;
    in_valid = 1'b1; in_inv = 1'b0; in_data = 32'hAAAA_0001;
    @(posedge clk); #1;
    in_data = 32'hBBBB_0002;
    @(posedge clk); #1;
    in_data = 32'hCCCC_0003;
    @(negedge clk);
    chk("full_in_ready", W'(in_ready), W'(0));
    chk("full_head", out_data, 32'hAAAA_0001);
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        break;
      end
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    for (int i = 0; i < W; i++) cfg_write(8'(i), 5'(des_p[i]));
    send_word(32'h0000_0001, 1'b0);
    expect_out(32'h0000_0100, "des_fwd");
`ifdef PERM_INV_EN
    send_word(32'h0000_0100, 1'b1);
    expect_out(32'h0000_0001, "des_inv");
`endif

    out_ready = 1'b0;
    send_word(32'h1111_1111, 1'b0);
    send_word(32'h2222_2222, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", W'(out_valid), W'(0));
    chk("midrst_in_ready", W'(in_ready), W'(1));
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send_word(32'h0000_0001, 1'b0);
    expect_out(32'h0000_0001, "identity_after_rst");

    cfg_we = 1'b1; cfg_addr = 8'd0; cfg_data = 5'd1;
    in_valid = 1'b1; in_data = 32'h2; in_inv = 1'b0;
    @(posedge clk); #1;
    cfg_we = 1'b0; in_valid = 1'b0;
    expect_out(32'h2, "same_cycle_old_tbl");
    send_word(32'h2, 1'b0);
    expect_out(32'h3, "same_cycle_new_tbl");

    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 499) != 0);
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      in_inv    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_we    = ($urandom_range(0, 15) == 0);
      cfg_addr  = 8'($urandom_range(0, 40));
      cfg_data  = 5'($urandom_range(0, 31));
      @(posedge clk); #1;
    end
    rst_n = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
